hazard_scoreboard: RTL and testbench

- Parametrised per-register RAW-hazard scoreboard that replaces fixed opcode-pair stall checks with latency countdowns.
- Sits beside the stall control logic at the ID→EX boundary.
- Records each issued producer's result latency by class (ALU/load/long-latency) and raises a stall when an ID-stage consumer's source is not yet forwardable.
- Handles flush of the just-issued instruction, global freeze (cache miss), stall-cycle counting and a stall watchdog.

---
 rtl/hazard_scoreboard_pkg.sv | 32 +++
 rtl/hazard_scoreboard_sb_counter_bank.sv | 51 +++++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg : producer classes and class-to-latency mapping
// Rev 1.0
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_NONE = 2'd0,
    SB_ALU  = 2'd1,
    SB_LOAD = 2'd2,
    SB_LONG = 2'd3
  } sb_class_t;

  function automatic int unsigned sb_latency(
    input sb_class_t   cls,
    input int unsigned lat_alu,
    input int unsigned lat_load,
    input int unsigned lat_long
  );
    int unsigned lat;
    case (cls)
      SB_ALU:  lat = lat_alu;
      SB_LOAD: lat = lat_load;
      SB_LONG: lat = lat_long;
      default: lat = 0;
    endcase
    return lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_counter_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_scoreboard_sb_counter_bank : per-register latency countdowns
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_scoreboard_sb_counter_bank #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                en_i,
  input  logic                                clr_i,
  input  logic [$clog2(NUM_REGS)-1:0]         clr_idx_i,
  input  logic                                ld_i,
  input  logic [$clog2(NUM_REGS)-1:0]         ld_idx_i,
  input  logic [CNT_W-1:0]                    ld_val_i,
  output logic [NUM_REGS-1:0][CNT_W-1:0]      cnt_o
);

  localparam int REG_W = $clog2(NUM_REGS);

  assign cnt_o[0] = '0;

  // Priority within a cycle: decrement, then flush-clear, then new issue (newest wins).
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '0)
        cnt_d = cnt_q - CNT_W'(1);
      if (clr_i && (clr_idx_i == REG_W'(r)))
        cnt_d = '0;
      if (ld_i && (ld_idx_i == REG_W'(r)))
        cnt_d = ld_val_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
        cnt_q <= '0;
      else if (en_i)
        cnt_q <= cnt_d;
    end

    assign cnt_o[r] = cnt_q;
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_scoreboard : latency-countdown RAW hazard detector for the ID/EX edge
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int LAT_ALU    = 1,
  parameter int LAT_LOAD   = 2,
  parameter int LAT_LONG   = 4,
  parameter int PERF_W     = 32,
  parameter int WDOG_LIMIT = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        freeze_i,
  input  logic                        issue_i,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd_i,
  input  sb_class_t                   issue_class_i,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs1_i,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs2_i,
  input  logic                        id_use_rs1_i,
  input  logic                        id_use_rs2_i,
  input  logic                        id_early_i,
  input  logic                        flush_ex_i,
  output logic                        raw_stall_o,
  output logic                        stall_rs1_o,
  output logic                        stall_rs2_o,
  output logic [PERF_W-1:0]           stall_cycles_o,
  output logic                        wdog_err_o
);

  localparam int REG_W    = $clog2(NUM_REGS);
  localparam int MAX_AL   = (LAT_ALU > LAT_LOAD) ? LAT_ALU : LAT_LOAD;
  localparam int MAX_LAT  = (MAX_AL > LAT_LONG) ? MAX_AL : LAT_LONG;
  localparam int CNT_W    = $clog2(MAX_LAT + 1);
  localparam int STREAK_W = $clog2(WDOG_LIMIT + 1);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]               slack;
  logic [CNT_W-1:0]               ld_val;
  logic                           accept;

  logic                           last_valid_q, last_valid_d;
  logic [REG_W-1:0]               last_rd_q, last_rd_d;
  logic [PERF_W-1:0]              stall_cycles_q, stall_cycles_d;
  logic [STREAK_W-1:0]            streak_q, streak_d;
  logic                           wdog_q, wdog_d;

  // A normal consumer picks the result up through forwarding one cycle earlier than an ID-resolving one.
  assign slack = id_early_i ? '0 : CNT_W'(1);

  assign stall_rs1_o = id_use_rs1_i && (id_rs1_i != '0) && (cnt[id_rs1_i] > slack);
  assign stall_rs2_o = id_use_rs2_i && (id_rs2_i != '0) && (cnt[id_rs2_i] > slack);
  assign raw_stall_o = stall_rs1_o | stall_rs2_o;

  assign accept = issue_i && !raw_stall_o && (issue_class_i != SB_NONE) && (issue_rd_i != '0);
  assign ld_val = CNT_W'(sb_latency(issue_class_i, LAT_ALU, LAT_LOAD, LAT_LONG));

  hazard_scoreboard_sb_counter_bank #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (!freeze_i),
    .clr_i     (flush_ex_i && last_valid_q),
    .clr_idx_i (last_rd_q),
    .ld_i      (accept),
    .ld_idx_i  (issue_rd_i),
    .ld_val_i  (ld_val),
    .cnt_o     (cnt)
  );

  always_comb begin
    last_valid_d   = accept;
    last_rd_d      = issue_rd_i;
    stall_cycles_d = stall_cycles_q;
    streak_d       = streak_q;
    wdog_d         = wdog_q;
    if (raw_stall_o) begin
      if (stall_cycles_q != {PERF_W{1'b1}})
        stall_cycles_d = stall_cycles_q + PERF_W'(1);
      if (streak_q < STREAK_W'(WDOG_LIMIT))
        streak_d = streak_q + STREAK_W'(1);
    end else begin
      streak_d = '0;
    end
    if (streak_d == STREAK_W'(WDOG_LIMIT))
      wdog_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_valid_q   <= 1'b0;
      last_rd_q      <= '0;
      stall_cycles_q <= '0;
      streak_q       <= '0;
      wdog_q         <= 1'b0;
    end else if (!freeze_i) begin
      last_valid_q   <= last_valid_d;
      last_rd_q      <= last_rd_d;
      stall_cycles_q <= stall_cycles_d;
      streak_q       <= streak_d;
      wdog_q         <= wdog_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign wdog_err_o     = wdog_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard : directed self-checking bench for hazard_scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic        issue;
  logic [4:0]  issue_rd;
  sb_class_t   issue_class;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        use1;
  logic        use2;
  logic        early;
  logic        flush_ex;
  logic        raw_stall;
  logic        stall_rs1;
  logic        stall_rs2;
  logic [31:0] stall_cycles;
  logic        wdog_err;

  int checks   = 0;
  int failures = 0;
  int exp_sc   = 0;

  hazard_scoreboard #(
    .NUM_REGS   (32),
    .LAT_ALU    (1),
    .LAT_LOAD   (2),
    .LAT_LONG   (4),
    .PERF_W     (32),
    .WDOG_LIMIT (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .freeze_i       (freeze),
    .issue_i        (issue),
    .issue_rd_i     (issue_rd),
    .issue_class_i  (issue_class),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_use_rs1_i   (use1),
    .id_use_rs2_i   (use2),
    .id_early_i     (early),
    .flush_ex_i     (flush_ex),
    .raw_stall_o    (raw_stall),
    .stall_rs1_o    (stall_rs1),
    .stall_rs2_o    (stall_rs2),
    .stall_cycles_o (stall_cycles),
    .wdog_err_o     (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    freeze = 0; issue = 0; issue_rd = 0; issue_class = SB_NONE;
    id_rs1 = 0; id_rs2 = 0; use1 = 0; use2 = 0; early = 0; flush_ex = 0;
    #1;
  endtask

  task automatic issue_op(input sb_class_t c, input logic [4:0] rd);
    clear_in();
    issue = 1; issue_class = c; issue_rd = rd;
    #1;
  endtask

  task automatic consumer(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic e);
    clear_in();
    id_rs1 = rs1; id_rs2 = rs2; use1 = u1; use2 = u2; early = e;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    consumer(5'd5, 5'd5, 1, 1, 1);
    tick(); tick();
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL reset_raw_stall: got %b want 0", raw_stall); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
    checks++; if (wdog_err !== 1'b0) begin failures++; $display("FAIL reset_wdog: got %b want 0", wdog_err); end
    rst_n = 1;
    clear_in();
    tick();
  endtask

  task automatic test_load_use();
    issue_op(SB_LOAD, 5'd5);
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL lu_issue_nostall: got %b want 0", raw_stall); end
    tick();
    consumer(5'd5, 5'd0, 1, 0, 0);
    checks++; if (raw_stall !== 1'b1) begin failures++; $display("FAIL lu_stall: got %b want 1", raw_stall); end
    checks++; if ({stall_rs1, stall_rs2} !== 2'b10) begin failures++; $display("FAIL lu_which: got %b want 10", {stall_rs1, stall_rs2}); end
    tick(); exp_sc++;
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL lu_release: got %b want 0", raw_stall); end
    checks++; if (stall_cycles !== 32'(exp_sc)) begin failures++; $display("FAIL lu_count: got %0d want %0d", stall_cycles, exp_sc); end
    clear_in(); tick();
  endtask

  task automatic test_early();
    issue_op(SB_LOAD, 5'd5); tick();
    consumer(5'd0, 5'd5, 0, 1, 1);
    checks++; if ({raw_stall, stall_rs1, stall_rs2} !== 3'b101) begin failures++; $display("FAIL early_load_c1: got %b want 101", {raw_stall, stall_rs1, stall_rs2}); end
    tick(); exp_sc++;
    checks++; if (raw_stall !== 1'b1) begin failures++; $display("FAIL early_load_c2: got %b want 1", raw_stall); end
    tick(); exp_sc++;
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL early_load_c3: got %b want 0", raw_stall); end
    clear_in(); tick();

    issue_op(SB_ALU, 5'd5); tick();
    consumer(5'd0, 5'd5, 0, 1, 1);
    checks++; if (raw_stall !== 1'b1) begin failures++; $display("FAIL early_alu_c1: got %b want 1", raw_stall); end
    tick(); exp_sc++;
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL early_alu_c2: got %b want 0", raw_stall); end
    clear_in(); tick();

    issue_op(SB_ALU, 5'd5); tick();
    consumer(5'd5, 5'd0, 1, 0, 0);
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL alu_add: got %b want 0", raw_stall); end
    clear_in(); tick();
    checks++; if (stall_cycles !== 32'(exp_sc)) begin failures++; $display("FAIL early_count: got %0d want %0d", stall_cycles, exp_sc); end
  endtask

  task automatic test_long_freeze();
    int seen;
    seen = 0;
    issue_op(SB_LONG, 5'd7); tick();
    consumer(5'd7, 5'd0, 1, 0, 0);
    if (raw_stall === 1'b1) seen++;
    tick(); exp_sc++;
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (raw_stall !== 1'b1) begin failures++; $display("FAIL frz_stall_%0d: got %b want 1", i, raw_stall); end
      if (raw_stall === 1'b1) seen++;
      tick();
    end
    checks++; if (stall_cycles !== 32'(exp_sc)) begin failures++; $display("FAIL frz_held_count: got %0d want %0d", stall_cycles, exp_sc); end
    freeze = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (raw_stall === 1'b1) begin seen++; exp_sc++; end
      tick();
    end
    checks++; if (seen !== 6) begin failures++; $display("FAIL frz_total_stall: got %0d want 6", seen); end
    checks++; if (stall_cycles !== 32'(exp_sc)) begin failures++; $display("FAIL frz_count: got %0d want %0d", stall_cycles, exp_sc); end
    clear_in(); tick();
  endtask

  task automatic test_flush_x0();
    issue_op(SB_LOAD, 5'd5); tick();
    clear_in(); flush_ex = 1; tick();
    consumer(5'd5, 5'd5, 1, 1, 1);
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL flush_nostall: got %b want 0", raw_stall); end
    tick();
    issue_op(SB_LOAD, 5'd0); tick();
    consumer(5'd0, 5'd0, 1, 1, 1);
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL x0_nostall: got %b want 0", raw_stall); end
    clear_in(); tick();
  endtask

  task automatic test_waw();
    issue_op(SB_LONG, 5'd3); tick();
    issue_op(SB_ALU, 5'd3); tick();
    consumer(5'd3, 5'd0, 1, 0, 0);
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL waw_add: got %b want 0", raw_stall); end
    consumer(5'd3, 5'd0, 1, 0, 1);
    checks++; if ({raw_stall, stall_rs1} !== 2'b11) begin failures++; $display("FAIL waw_cnt1_early: got %b want 11", {raw_stall, stall_rs1}); end
    clear_in(); tick();
  endtask

  task automatic test_watchdog();
    issue_op(SB_LONG, 5'd9); tick();
    consumer(5'd9, 5'd0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({raw_stall, wdog_err} !== 2'b10) begin failures++; $display("FAIL wdog_streak_%0d: got %b want 10", i, {raw_stall, wdog_err}); end
      tick(); exp_sc++;
    end
    checks++; if ({raw_stall, wdog_err} !== 2'b01) begin failures++; $display("FAIL wdog_fire: got %b want 01", {raw_stall, wdog_err}); end
    clear_in(); tick(); tick();
    checks++; if (wdog_err !== 1'b1) begin failures++; $display("FAIL wdog_sticky: got %b want 1", wdog_err); end
    checks++; if (stall_cycles !== 32'(exp_sc)) begin failures++; $display("FAIL wdog_count: got %0d want %0d", stall_cycles, exp_sc); end
  endtask

  task automatic test_async_reset();
    issue_op(SB_LONG, 5'd9); tick();
    consumer(5'd9, 5'd0, 1, 0, 0);
    checks++; if (raw_stall !== 1'b1) begin failures++; $display("FAIL ar_pre_stall: got %b want 1", raw_stall); end
    rst_n = 0;
    #1;
    checks++; if ({raw_stall, stall_rs1, stall_rs2, wdog_err} !== 4'b0000) begin failures++; $display("FAIL ar_flags: got %b want 0000", {raw_stall, stall_rs1, stall_rs2, wdog_err}); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL ar_count: got %0d want 0", stall_cycles); end
    tick();
    rst_n = 1;
    tick();
    checks++; if (raw_stall !== 1'b0) begin failures++; $display("FAIL ar_cleared_hazard: got %b want 0", raw_stall); end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_load_use();
    test_early();
    test_long_freeze();
    test_flush_x0();
    test_waw();
    test_watchdog();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
